// File: rtl/mem_stage_if.sv
// Bundle between EX, the memory stage, data memory and writeback.
// Covers the EX handshake, the dmem req/ack port and the WB/PC outputs.
interface mem_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    op;
  logic [DW-1:0] alu_o;
  logic [DW-1:0] addr_o;
  logic          ife;
  logic [RW-1:0] rd;

  logic          dmem_req;
  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_ack;

  logic          wb_valid;
  logic          wb_we;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          pc_sel;
  logic [DW-1:0] pc_target;
  logic          mem_err;

  modport slave (
    input  in_valid, op, alu_o, addr_o, ife, rd,
    input  dmem_rdata, dmem_ack,
    output in_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output wb_valid, wb_we, wb_rd, wb_data,
    output pc_sel, pc_target, mem_err
  );

  modport master (
    output in_valid, op, alu_o, addr_o, ife, rd,
    output dmem_rdata, dmem_ack,
    input  in_ready,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  wb_valid, wb_we, wb_rd, wb_data,
    input  pc_sel, pc_target, mem_err
  );
endinterface

// File: rtl/mem_stage.sv
// Memory / writeback-select stage: SW/LW over req/ack, BEQ/JMP redirect.
// Optional macro MEM_TIMEOUT_EN: abort a dmem access after TMO_CYC cycles.
module mem_stage #(
  parameter int DW      = 32,
  parameter int RW      = 5,
  parameter int TMO_CYC = 16
) (
  input logic       clk,
  input logic       rst,
  mem_stage_if.slave io_bus
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        r_state, w_state_n;

  logic          r_dmem_req,   w_dmem_req_n;
  logic          r_dmem_we,    w_dmem_we_n;
  logic [DW-1:0] r_dmem_addr,  w_dmem_addr_n;
  logic [DW-1:0] r_dmem_wdata, w_dmem_wdata_n;
  logic [RW-1:0] r_rd_pend,    w_rd_pend_n;

  logic          r_wb_valid,   w_wb_valid_n;
  logic          r_wb_we,      w_wb_we_n;
  logic [RW-1:0] r_wb_rd,      w_wb_rd_n;
  logic [DW-1:0] r_wb_data,    w_wb_data_n;
  logic          r_pc_sel,     w_pc_sel_n;
  logic [DW-1:0] r_pc_target,  w_pc_target_n;
  logic          r_mem_err,    w_mem_err_n;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYC + 1);
  logic [CW-1:0] r_cnt, w_cnt_n;
`else
  logic          w_unused_tmo;
  assign w_unused_tmo = ^TMO_CYC;
`endif

  logic w_accept;
  logic w_is_alu, w_is_sw, w_is_lw;
  logic w_is_beq, w_is_jmp;

  assign io_bus.in_ready = (r_state == S_IDLE);
  assign w_accept = io_bus.in_valid &
                    io_bus.in_ready;

  assign w_is_alu = (io_bus.op[5:3] == 3'b000) &&
                    (io_bus.op[2:0] <= 3'd5);
  assign w_is_sw  = (io_bus.op == 6'b010000);
  assign w_is_lw  = (io_bus.op == 6'b010001);
  assign w_is_beq = (io_bus.op == 6'b100000);
  assign w_is_jmp = (io_bus.op == 6'b100001);

  // State and registered outputs, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_rd_pend    <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_we      <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_pc_sel     <= 1'b0;
      r_pc_target  <= '0;
      r_mem_err    <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_dmem_req   <= w_dmem_req_n;
      r_dmem_we    <= w_dmem_we_n;
      r_dmem_addr  <= w_dmem_addr_n;
      r_dmem_wdata <= w_dmem_wdata_n;
      r_rd_pend    <= w_rd_pend_n;
      r_wb_valid   <= w_wb_valid_n;
      r_wb_we      <= w_wb_we_n;
      r_wb_rd      <= w_wb_rd_n;
      r_wb_data    <= w_wb_data_n;
      r_pc_sel     <= w_pc_sel_n;
      r_pc_target  <= w_pc_target_n;
      r_mem_err    <= w_mem_err_n;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Wait-cycle counter for the dmem timeout.
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_cnt_n;
  end
`endif

  // Next state and next values of every registered output.
  always_comb begin
    w_state_n      = r_state;
    w_dmem_req_n   = r_dmem_req;
    w_dmem_we_n    = r_dmem_we;
    w_dmem_addr_n  = r_dmem_addr;
    w_dmem_wdata_n = r_dmem_wdata;
    w_rd_pend_n    = r_rd_pend;
    w_wb_valid_n   = 1'b0;
    w_wb_we_n      = r_wb_we;
    w_wb_rd_n      = r_wb_rd;
    w_wb_data_n    = r_wb_data;
    w_pc_sel_n     = 1'b0;
    w_pc_target_n  = r_pc_target;
    w_mem_err_n    = 1'b0;
`ifdef MEM_TIMEOUT_EN
    w_cnt_n        = r_cnt;
`endif

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          unique case (1'b1)
            w_is_alu: begin
              w_wb_valid_n = 1'b1;
              w_wb_we_n    = 1'b1;
              w_wb_rd_n    = io_bus.rd;
              w_wb_data_n  = io_bus.alu_o;
            end
            w_is_sw, w_is_lw: begin
              w_dmem_req_n   = 1'b1;
              w_dmem_we_n    = w_is_sw;
              w_dmem_addr_n  = io_bus.addr_o;
              w_dmem_wdata_n = io_bus.alu_o;
              w_rd_pend_n    = io_bus.rd;
              w_state_n      = S_WAIT;
`ifdef MEM_TIMEOUT_EN
              w_cnt_n        = '0;
`endif
            end
            w_is_beq, w_is_jmp: begin
              w_wb_valid_n  = 1'b1;
              w_wb_we_n     = 1'b0;
              w_wb_rd_n     = io_bus.rd;
              w_pc_sel_n    = w_is_jmp | io_bus.ife;
              w_pc_target_n = io_bus.addr_o;
            end
            default: begin
              w_wb_valid_n = 1'b1;
              w_wb_we_n    = 1'b0;
              w_wb_rd_n    = io_bus.rd;
            end
          endcase
        end
      end
      S_WAIT: begin
        if (io_bus.dmem_ack) begin
          w_dmem_req_n = 1'b0;
          w_wb_valid_n = 1'b1;
          w_wb_we_n    = ~r_dmem_we;
          w_wb_rd_n    = r_rd_pend;
          if (!r_dmem_we)
            w_wb_data_n = io_bus.dmem_rdata;
          w_state_n    = S_IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (r_cnt == CW'(TMO_CYC - 1)) begin
          w_dmem_req_n = 1'b0;
          w_wb_valid_n = 1'b1;
          w_wb_we_n    = 1'b0;
          w_wb_rd_n    = r_rd_pend;
          w_mem_err_n  = 1'b1;
          w_state_n    = S_IDLE;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
`endif
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign io_bus.dmem_req   = r_dmem_req;
  assign io_bus.dmem_we    = r_dmem_we;
  assign io_bus.dmem_addr  = r_dmem_addr;
  assign io_bus.dmem_wdata = r_dmem_wdata;
  assign io_bus.wb_valid   = r_wb_valid;
  assign io_bus.wb_we      = r_wb_we;
  assign io_bus.wb_rd      = r_wb_rd;
  assign io_bus.wb_data    = r_wb_data;
  assign io_bus.pc_sel     = r_pc_sel;
  assign io_bus.pc_target  = r_pc_target;
`ifdef MEM_TIMEOUT_EN
  assign io_bus.mem_err    = r_mem_err;
`else
  assign io_bus.mem_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU, LW/SW, branch, reset, timeout.
// Inputs driven and outputs sampled on the falling edge.
module tb_mem_stage;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  mem_stage_if #(.DW(32), .RW(5)) u_if ();

  mem_stage #(
    .DW(32), .RW(5), .TMO_CYC(4)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v,
                       input logic [5:0] op,
                       input logic [31:0] alu,
                       input logic [31:0] addr,
                       input logic ife,
                       input logic [4:0] rd);
    u_if.in_valid = v;
    u_if.op       = op;
    u_if.alu_o    = alu;
    u_if.addr_o   = addr;
    u_if.ife      = ife;
    u_if.rd       = rd;
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  logic [31:0] alu_v [3];
  logic [4:0]  rd_v  [3];
  logic [5:0]  op_v  [3];

  initial begin
    n_chk = 0;
    n_err = 0;
    alu_v = '{32'h11, 32'h22, 32'h33};
    rd_v  = '{5'd4, 5'd5, 5'd6};
    op_v  = '{6'd1, 6'd5, 6'd3};
    rst = 1'b1;
    drive(0, 6'd0, 0, 0, 0, 0);
    u_if.dmem_ack   = 1'b0;
    u_if.dmem_rdata = '0;
    repeat (2) nedge();
    check("rst_wb_valid", u_if.wb_valid, 0);
    check("rst_req", u_if.dmem_req, 0);
    check("rst_pc_sel", u_if.pc_sel, 0);
    check("rst_wb_data", u_if.wb_data, 0);
    check("rst_ready", u_if.in_ready, 1);
    check("rst_err", u_if.mem_err, 0);
    rst = 1'b0;

    // single ALU op, latency 1
    drive(1, 6'd0, 32'h5, 0, 0, 5'd3);
    nedge();
    check("alu_valid", u_if.wb_valid, 1);
    check("alu_we", u_if.wb_we, 1);
    check("alu_rd", u_if.wb_rd, 3);
    check("alu_data", u_if.wb_data, 32'h5);

    // three back-to-back ALU ops
    for (int i = 0; i < 3; i++) begin
      drive(1, op_v[i], alu_v[i], 0, 0, rd_v[i]);
      nedge();
      check("b2b_valid", u_if.wb_valid, 1);
      check("b2b_data", u_if.wb_data, alu_v[i]);
      check("b2b_rd", u_if.wb_rd, rd_v[i]);
    end
    drive(0, 6'd0, 0, 0, 0, 0);
    nedge();
    check("idle_valid", u_if.wb_valid, 0);
    check("hold_data", u_if.wb_data, 32'h33);

    // LW, ack on third req cycle
    drive(1, 6'b010001, 0, 32'h40, 0, 5'd7);
    nedge();
    drive(0, 6'd0, 0, 0, 0, 0);
    check("lw_req1", u_if.dmem_req, 1);
    check("lw_we", u_if.dmem_we, 0);
    check("lw_addr", u_if.dmem_addr, 32'h40);
    check("lw_ready", u_if.in_ready, 0);
    check("lw_novalid", u_if.wb_valid, 0);
    nedge();
    check("lw_req2", u_if.dmem_req, 1);
    check("lw_addr2", u_if.dmem_addr, 32'h40);
    nedge();
    check("lw_req3", u_if.dmem_req, 1);
    u_if.dmem_ack   = 1'b1;
    u_if.dmem_rdata = 32'hDEADBEEF;
    nedge();
    u_if.dmem_ack   = 1'b0;
    u_if.dmem_rdata = '0;
    check("lw_req_drop", u_if.dmem_req, 0);
    check("lw_valid", u_if.wb_valid, 1);
    check("lw_wb_we", u_if.wb_we, 1);
    check("lw_wb_rd", u_if.wb_rd, 7);
    check("lw_data", u_if.wb_data, 32'hDEADBEEF);
    check("lw_ready_back", u_if.in_ready, 1);
    check("lw_err", u_if.mem_err, 0);

    // SW, ack in the same cycle as req
    drive(1, 6'b010000, 32'h1234, 32'h10, 0, 5'd9);
    nedge();
    drive(0, 6'd0, 0, 0, 0, 0);
    check("sw_req", u_if.dmem_req, 1);
    check("sw_we", u_if.dmem_we, 1);
    check("sw_addr", u_if.dmem_addr, 32'h10);
    check("sw_wdata", u_if.dmem_wdata, 32'h1234);
    u_if.dmem_ack = 1'b1;
    nedge();
    u_if.dmem_ack = 1'b0;
    check("sw_valid", u_if.wb_valid, 1);
    check("sw_wb_we", u_if.wb_we, 0);
    check("sw_req_drop", u_if.dmem_req, 0);
    check("sw_keep_data", u_if.wb_data, 32'hDEADBEEF);

    // stray ack with no request
    u_if.dmem_ack = 1'b1;
    nedge();
    u_if.dmem_ack = 1'b0;
    nedge();
    check("stray_valid", u_if.wb_valid, 0);
    check("stray_req", u_if.dmem_req, 0);

    // branches and jump
    drive(1, 6'b100000, 0, 32'h100, 1, 0);
    nedge();
    check("beq_t_sel", u_if.pc_sel, 1);
    check("beq_t_tgt", u_if.pc_target, 32'h100);
    check("beq_t_valid", u_if.wb_valid, 1);
    check("beq_t_we", u_if.wb_we, 0);
    drive(1, 6'b100000, 0, 32'h200, 0, 0);
    nedge();
    check("beq_n_sel", u_if.pc_sel, 0);
    check("beq_n_valid", u_if.wb_valid, 1);
    drive(1, 6'b100001, 0, 32'h80, 0, 0);
    nedge();
    check("jmp_sel", u_if.pc_sel, 1);
    check("jmp_tgt", u_if.pc_target, 32'h80);
    drive(1, 6'b111111, 32'h99, 0, 0, 5'd2);
    nedge();
    check("nop_sel", u_if.pc_sel, 0);
    check("nop_valid", u_if.wb_valid, 1);
    check("nop_we", u_if.wb_we, 0);
    check("nop_req", u_if.dmem_req, 0);
    drive(0, 6'd0, 0, 0, 0, 0);
    nedge();
    check("pulse_end", u_if.wb_valid, 0);

    // reset while waiting on memory
    drive(1, 6'b010001, 0, 32'h44, 0, 5'd8);
    nedge();
    drive(0, 6'd0, 0, 0, 0, 0);
    check("rw_req", u_if.dmem_req, 1);
    rst = 1'b1;
    nedge();
    rst = 1'b0;
    check("rw_req0", u_if.dmem_req, 0);
    check("rw_valid0", u_if.wb_valid, 0);
    check("rw_ready", u_if.in_ready, 1);
    u_if.dmem_ack   = 1'b1;
    u_if.dmem_rdata = 32'hCAFE;
    nedge();
    u_if.dmem_ack   = 1'b0;
    check("late_valid", u_if.wb_valid, 0);
    check("late_req", u_if.dmem_req, 0);

`ifdef MEM_TIMEOUT_EN
    // LW with no ack times out after 4 wait cycles
    drive(1, 6'b010001, 0, 32'h50, 0, 5'd1);
    nedge();
    drive(0, 6'd0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check("tmo_req", u_if.dmem_req, 1);
      check("tmo_noerr", u_if.mem_err, 0);
      nedge();
    end
    check("tmo_drop", u_if.dmem_req, 0);
    check("tmo_err", u_if.mem_err, 1);
    check("tmo_valid", u_if.wb_valid, 1);
    check("tmo_we", u_if.wb_we, 0);
    nedge();
    check("tmo_err_pulse", u_if.mem_err, 0);
`else
    // without timeout the access waits indefinitely
    drive(1, 6'b010001, 0, 32'h50, 0, 5'd1);
    nedge();
    drive(0, 6'd0, 0, 0, 0, 0);
    repeat (20) nedge();
    check("wait_req", u_if.dmem_req, 1);
    check("wait_err", u_if.mem_err, 0);
    check("wait_valid", u_if.wb_valid, 0);
    u_if.dmem_ack = 1'b1;
    nedge();
    u_if.dmem_ack = 1'b0;
    check("wait_done", u_if.wb_valid, 1);
`endif

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
